// File: rtl/log_install_sched_pkg.sv
// Shared types and constants for the log install scheduler.
package log_install_sched_pkg;

    localparam int NUM_INSTALL_REQ = 2;
    localparam int INT_W           = 32;
    localparam int LOG_HDR_DEPTH_W = 10;
    localparam int TAIL_W          = LOG_HDR_DEPTH_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_STREAM    = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESP      = 3'd4
    } sched_state_e;

    typedef struct packed {
        logic [INT_W-1:0]  first_log_op;
        logic [INT_W-1:0]  last_commit;
        logic [TAIL_W-1:0] hdr_log_tail;
        logic [TAIL_W-1:0] data_log_tail;
    } install_result_struct;

    // One-hot vector for a requester index.
    function automatic logic [NUM_INSTALL_REQ-1:0] onehot_of(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/log_install_sched_rr_arb_2.sv
// Two-input round-robin picker: combinational pick, pointer advanced past the served requester.
module rr_arb_2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_ptr_upd,
    input  logic       i_served,
    output logic       o_any,
    output logic       o_pick
);

    logic r_rr_ptr;

    // Pointer moves to the requester that was not just served once its message completes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr_ptr <= 1'b0;
        end else if (i_ptr_upd) begin
            r_rr_ptr <= ~i_served;
        end
    end

    // Prefer the pointer's requester, fall back to the other one.
    always_comb begin
        o_any  = |i_req;
        o_pick = r_rr_ptr;
        if (!i_req[r_rr_ptr]) begin
            o_pick = ~r_rr_ptr;
        end
    end

endmodule

// File: rtl/log_install_sched.sv
// Shares the log install datapath between the start-view and recovery handlers,
// locking the grant for a whole message and returning latched install results.
module log_install_sched
    import log_install_sched_pkg::*;
#(
    parameter int NOC_DATA_W     = 512,
    parameter int NOC_PADBYTES_W = 6
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [1:0]                  i_req_start,
    output logic [1:0]                  o_req_grant,
    input  logic [1:0]                  i_req_data_val,
    input  logic [2*NOC_DATA_W-1:0]     i_req_data,
    input  logic [1:0]                  i_req_data_last,
    input  logic [2*NOC_PADBYTES_W-1:0] i_req_data_padbytes,
    output logic [1:0]                  o_req_data_rdy,
    output logic                        o_start_log_install,
    output logic                        o_install_req_val,
    output logic [NOC_DATA_W-1:0]       o_install_req,
    output logic                        o_install_req_last,
    output logic [NOC_PADBYTES_W-1:0]   o_install_req_padbytes,
    input  logic                        i_install_req_rdy,
    input  logic                        i_log_install_rdy,
    input  logic [INT_W-1:0]            i_first_log_op_in,
    input  logic [INT_W-1:0]            i_last_commit_in,
    input  logic [TAIL_W-1:0]           i_hdr_log_tail_in,
    input  logic [TAIL_W-1:0]           i_data_log_tail_in,
    output logic [1:0]                  o_done_val,
    input  logic [1:0]                  i_done_rdy,
    output logic [INT_W-1:0]            o_done_first_log_op,
    output logic [INT_W-1:0]            o_done_last_commit,
    output logic [TAIL_W-1:0]           o_done_hdr_log_tail,
    output logic [TAIL_W-1:0]           o_done_data_log_tail
);

    sched_state_e         r_state;
    sched_state_e         w_next_state;
    logic                 r_winner;
    logic [1:0]           r_grant;
    logic                 r_wait_armed;
    install_result_struct r_result;

    logic w_any;
    logic w_pick;
    logic w_ptr_upd;
    logic w_beat_fire;

    rr_arb_2 u_arb (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req     (i_req_start),
        .i_ptr_upd (w_ptr_upd),
        .i_served  (r_winner),
        .o_any     (w_any),
        .o_pick    (w_pick)
    );

    assign w_beat_fire = (r_state == ST_STREAM) && i_req_data_val[r_winner] && i_install_req_rdy;

    // Next-state logic; the pointer only advances on the completion handshake.
    always_comb begin
        w_next_state = r_state;
        w_ptr_upd    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_next_state = ST_START;
                end
            end
            ST_START: begin
                w_next_state = ST_STREAM;
            end
            ST_STREAM: begin
                if (w_beat_fire && i_req_data_last[r_winner]) begin
                    w_next_state = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (r_wait_armed && i_log_install_rdy) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (i_done_rdy[r_winner]) begin
                    w_next_state = ST_IDLE;
                    w_ptr_upd    = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, grant lock and result capture; the first WAIT_DONE cycle ignores a stale ready.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_winner     <= 1'b0;
            r_grant      <= 2'b00;
            r_wait_armed <= 1'b0;
            r_result     <= '0;
        end else begin
            r_state      <= w_next_state;
            r_wait_armed <= (r_state == ST_WAIT_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_winner <= w_pick;
                        r_grant  <= onehot_of(w_pick);
                    end
                end
                ST_WAIT_DONE: begin
                    if (r_wait_armed && i_log_install_rdy) begin
                        r_result.first_log_op  <= i_first_log_op_in;
                        r_result.last_commit   <= i_last_commit_in;
                        r_result.hdr_log_tail  <= i_hdr_log_tail_in;
                        r_result.data_log_tail <= i_data_log_tail_in;
                    end
                end
                ST_RESP: begin
                    if (i_done_rdy[r_winner]) begin
                        r_grant <= 2'b00;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode: start pulse, winner stream steering and done valid.
    always_comb begin
        o_req_grant            = r_grant;
        o_start_log_install    = (r_state == ST_START);
        o_install_req_val      = 1'b0;
        o_install_req          = '0;
        o_install_req_last     = 1'b0;
        o_install_req_padbytes = '0;
        o_req_data_rdy         = 2'b00;
        o_done_val             = 2'b00;
        if (r_state == ST_STREAM) begin
            o_install_req_val  = i_req_data_val[r_winner];
            o_install_req_last = i_req_data_last[r_winner];
            o_req_data_rdy     = onehot_of(r_winner) & {2{i_install_req_rdy}};
            if (r_winner) begin
                o_install_req          = i_req_data[2*NOC_DATA_W-1:NOC_DATA_W];
                o_install_req_padbytes = i_req_data_padbytes[2*NOC_PADBYTES_W-1:NOC_PADBYTES_W];
            end else begin
                o_install_req          = i_req_data[NOC_DATA_W-1:0];
                o_install_req_padbytes = i_req_data_padbytes[NOC_PADBYTES_W-1:0];
            end
        end
        if (r_state == ST_RESP) begin
            o_done_val = onehot_of(r_winner);
        end
    end

    assign o_done_first_log_op  = r_result.first_log_op;
    assign o_done_last_commit   = r_result.last_commit;
    assign o_done_hdr_log_tail  = r_result.hdr_log_tail;
    assign o_done_data_log_tail = r_result.data_log_tail;

endmodule

// File: tb/tb_log_install_sched.sv
// Self-checking bench for log_install_sched: bench-side requesters and install
// controller, with arbitration order and message contents predicted by the bench.
module tb_log_install_sched;
    import log_install_sched_pkg::*;

    localparam int DW = 512;
    localparam int PW = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        pending = 2'b00;
    logic [1:0]        grant;
    logic [1:0]        reqVal = 2'b00;
    logic [2*DW-1:0]   reqData = '0;
    logic [1:0]        reqLast = 2'b00;
    logic [2*PW-1:0]   reqPad = '0;
    logic [1:0]        reqRdy;
    logic              startPulse;
    logic              insVal;
    logic [DW-1:0]     insData;
    logic              insLast;
    logic [PW-1:0]     insPad;
    logic              insReqRdy = 1'b0;
    logic              logRdy = 1'b0;
    logic [INT_W-1:0]  firstIn = '0;
    logic [INT_W-1:0]  commitIn = '0;
    logic [TAIL_W-1:0] hdrIn = '0;
    logic [TAIL_W-1:0] dataIn = '0;
    logic [1:0]        doneVal;
    logic [1:0]        doneRdy = 2'b00;
    logic [INT_W-1:0]  doneFirst;
    logic [INT_W-1:0]  doneCommit;
    logic [TAIL_W-1:0] doneHdr;
    logic [TAIL_W-1:0] doneData;

    int total = 0;
    int bad = 0;
    int lastServed = 1;
    int lastGrantIdx = -1;
    logic [INT_W-1:0]  resFirst;
    logic [INT_W-1:0]  resCommit;
    logic [TAIL_W-1:0] resHdr;
    logic [TAIL_W-1:0] resData;
    logic [PW-1:0]     resPad;

    always #5 clk = ~clk;

    log_install_sched dut (
        .i_clk                  (clk),
        .i_rst_n                (rst_n),
        .i_req_start            (pending),
        .o_req_grant            (grant),
        .i_req_data_val         (reqVal),
        .i_req_data             (reqData),
        .i_req_data_last        (reqLast),
        .i_req_data_padbytes    (reqPad),
        .o_req_data_rdy         (reqRdy),
        .o_start_log_install    (startPulse),
        .o_install_req_val      (insVal),
        .o_install_req          (insData),
        .o_install_req_last     (insLast),
        .o_install_req_padbytes (insPad),
        .i_install_req_rdy      (insReqRdy),
        .i_log_install_rdy      (logRdy),
        .i_first_log_op_in      (firstIn),
        .i_last_commit_in       (commitIn),
        .i_hdr_log_tail_in      (hdrIn),
        .i_data_log_tail_in     (dataIn),
        .o_done_val             (doneVal),
        .i_done_rdy             (doneRdy),
        .o_done_first_log_op    (doneFirst),
        .o_done_last_commit     (doneCommit),
        .o_done_hdr_log_tail    (doneHdr),
        .o_done_data_log_tail   (doneData)
    );

    // Count one comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] randBeat();
        logic [DW-1:0] b;
        for (int i = 0; i < DW / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // Drive the winner's beat; the other requester always offers garbage with valid high.
    task automatic applyStimulus(input int w, input logic [DW-1:0] beat, input logic val,
                                 input logic last, input logic [PW-1:0] pad, input logic insRdy);
        int other;
        other = 1 - w;
        reqData[w*DW +: DW]     = beat;
        reqData[other*DW +: DW] = randBeat();
        reqVal[w]               = val;
        reqVal[other]           = 1'b1;
        reqLast[w]              = last;
        reqLast[other]          = 1'($urandom_range(0, 1));
        reqPad[w*PW +: PW]      = pad;
        reqPad[other*PW +: PW]  = PW'($urandom_range(0, 63));
        insReqRdy               = insRdy;
    endtask

    function automatic logic [1:0] oneHot(input int idx);
        return (idx == 1) ? 2'b10 : 2'b01;
    endfunction

    // One complete message: grant, stream, install completion and done handshake.
    task automatic serveOne(input int nBeats, input int bpMode, input bit stale, input int holdCycles);
        logic [DW-1:0] beats[$];
        int w, other, idx, cyc, k, got, delay, startPulses;
        logic v, r, isLast;
        if (pending == 2'b11) w = (lastServed == 0) ? 1 : 0;
        else w = pending[1] ? 1 : 0;
        other = 1 - w;
        for (int i = 0; i < nBeats; i++) beats.push_back(randBeat());
        delay = $urandom_range(0, 3);
        startPulses = 0;

        got = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            @(negedge clk);
            applyStimulus(w, beats[0], 1'b1, nBeats == 1, (nBeats == 1) ? resPad : '0, 1'b1);
            #1;
            if (startPulse) startPulses++;
            if (grant != 2'b00) got = 1;
            else begin
                checkOutput("idle_data_rdy", DW'(reqRdy), DW'(2'b00));
                checkOutput("idle_ins_val", DW'(insVal), DW'(1'b0));
            end
        end
        checkOutput("grant_seen", DW'(got), DW'(1));
        if (got == 0) return;
        lastGrantIdx = grant[1] ? 1 : 0;
        checkOutput("grant_onehot", DW'(grant), DW'(oneHot(w)));
        checkOutput("start_at_grant", DW'(startPulse), DW'(1'b1));
        checkOutput("start_ins_val", DW'(insVal), DW'(1'b0));
        pending[w] = 1'b0;

        idx = 0;
        cyc = 0;
        while (idx < nBeats && cyc < 200) begin
            @(negedge clk);
            case (bpMode)
                0: begin v = 1'b1; r = 1'b1; end
                1: begin v = (cyc % 4 == 1) || (cyc % 4 == 2); r = (cyc % 2 == 0); end
                default: begin v = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1)); end
            endcase
            isLast = (idx == nBeats - 1);
            applyStimulus(w, beats[idx], v, isLast, isLast ? resPad : '0, r);
            logRdy   = stale;
            firstIn  = stale ? ~resFirst : INT_W'($urandom);
            commitIn = stale ? ~resCommit : INT_W'($urandom);
            hdrIn    = stale ? ~resHdr : TAIL_W'($urandom);
            dataIn   = stale ? ~resData : TAIL_W'($urandom);
            #1;
            if (startPulse) startPulses++;
            checkOutput("loser_rdy", DW'(reqRdy[other]), DW'(1'b0));
            checkOutput("winner_rdy", DW'(reqRdy[w]), DW'(r));
            checkOutput("ins_val", DW'(insVal), DW'(v));
            if (v && r) begin
                checkOutput("beat_data", insData, beats[idx]);
                checkOutput("beat_last", DW'(insLast), DW'(isLast));
                checkOutput("beat_pad", DW'(insPad), DW'(isLast ? resPad : '0));
                idx++;
            end
            cyc++;
        end
        checkOutput("stream_complete", DW'(idx), DW'(nBeats));

        got = 0;
        k = 0;
        for (int c = 1; c <= 20 && got == 0; c++) begin
            @(negedge clk);
            k = c;
            reqVal[w] = 1'b0;
            if (stale) begin
                logRdy   = 1'b1;
                firstIn  = (c <= 1) ? ~resFirst : resFirst;
                commitIn = (c <= 1) ? ~resCommit : resCommit;
                hdrIn    = (c <= 1) ? ~resHdr : resHdr;
                dataIn   = (c <= 1) ? ~resData : resData;
            end else begin
                logRdy   = (c > delay);
                firstIn  = resFirst;
                commitIn = resCommit;
                hdrIn    = resHdr;
                dataIn   = resData;
            end
            #1;
            if (startPulse) startPulses++;
            if (c == 1) checkOutput("no_early_done", DW'(doneVal), DW'(2'b00));
            if (doneVal != 2'b00) got = 1;
        end
        checkOutput("done_seen", DW'(got), DW'(1));
        checkOutput("done_latency_min", DW'(k >= 2), DW'(1'b1));
        checkOutput("done_val", DW'(doneVal), DW'(oneHot(w)));
        checkOutput("done_first", DW'(doneFirst), DW'(resFirst));
        checkOutput("done_commit", DW'(doneCommit), DW'(resCommit));
        checkOutput("done_hdr", DW'(doneHdr), DW'(resHdr));
        checkOutput("done_data", DW'(doneData), DW'(resData));

        for (int h = 0; h < holdCycles; h++) begin
            @(negedge clk);
            logRdy         = 1'b0;
            firstIn        = INT_W'($urandom);
            commitIn       = INT_W'($urandom);
            hdrIn          = TAIL_W'($urandom);
            dataIn         = TAIL_W'($urandom);
            doneRdy[w]     = 1'b0;
            doneRdy[other] = 1'($urandom_range(0, 1));
            #1;
            checkOutput("hold_val", DW'(doneVal), DW'(oneHot(w)));
            checkOutput("hold_first", DW'(doneFirst), DW'(resFirst));
            checkOutput("hold_commit", DW'(doneCommit), DW'(resCommit));
            checkOutput("hold_tails", DW'({doneHdr, doneData}), DW'({resHdr, resData}));
            checkOutput("hold_grant", DW'(grant), DW'(oneHot(w)));
        end

        @(negedge clk);
        logRdy         = 1'b0;
        doneRdy[w]     = 1'b1;
        doneRdy[other] = 1'($urandom_range(0, 1));
        #1;
        checkOutput("done_val_at_hs", DW'(doneVal), DW'(oneHot(w)));
        checkOutput("grant_at_hs", DW'(grant), DW'(oneHot(w)));

        @(negedge clk);
        doneRdy = 2'b00;
        #1;
        checkOutput("done_val_after", DW'(doneVal), DW'(2'b00));
        checkOutput("grant_after", DW'(grant), DW'(2'b00));
        checkOutput("start_pulses", DW'(startPulses), DW'(1));
        lastServed = w;
    endtask

    task automatic randomResults();
        resFirst  = INT_W'($urandom) | 1;
        resCommit = INT_W'($urandom) | 1;
        resHdr    = TAIL_W'($urandom) | 1;
        resData   = TAIL_W'($urandom) | 1;
        resPad    = PW'($urandom_range(0, 63));
    endtask

    // Safety net so the bench can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence of scenarios with randomized data.
    initial begin
        int expOrder[4];
        expOrder = '{0, 1, 0, 1};
        randomResults();

        #12;
        checkOutput("reset_grant", DW'(grant), DW'(2'b00));
        checkOutput("reset_done_val", DW'(doneVal), DW'(2'b00));
        checkOutput("reset_start", DW'(startPulse), DW'(1'b0));
        checkOutput("reset_done_first", DW'(doneFirst), DW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("idle_no_grant", DW'(grant), DW'(2'b00));

        $display("[TB] simultaneous requests");
        pending = 2'b11;
        randomResults();
        serveOne(2, 0, 1'b0, 1);
        checkOutput("simul_first", DW'(lastGrantIdx), DW'(0));
        randomResults();
        serveOne(2, 2, 1'b0, 0);
        checkOutput("simul_second", DW'(lastGrantIdx), DW'(1));

        $display("[TB] fairness");
        for (int m = 0; m < 4; m++) begin
            pending = 2'b11;
            randomResults();
            serveOne(1 + m, 2, 1'b0, m % 3);
            checkOutput("fair_order", DW'(lastGrantIdx), DW'(expOrder[m]));
        end
        pending = 2'b00;
        @(negedge clk);
        @(negedge clk);

        $display("[TB] single requester");
        pending   = 2'b01;
        resFirst  = 32'h10;
        resCommit = 32'h0F;
        resHdr    = 11'd3;
        resData   = 11'd7;
        resPad    = 6'd5;
        serveOne(3, 0, 1'b0, 2);
        checkOutput("single_idx", DW'(lastGrantIdx), DW'(0));

        $display("[TB] backpressure");
        pending = 2'b10;
        randomResults();
        serveOne(4, 1, 1'b0, 1);

        $display("[TB] stale ready");
        pending = 2'b01;
        randomResults();
        serveOne(2, 0, 1'b1, 5);

        $display("[TB] random traffic");
        for (int m = 0; m < 6; m++) begin
            pending = 2'($urandom_range(1, 3));
            randomResults();
            serveOne($urandom_range(1, 5), 2, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end
        pending = 2'b00;

        $display("[TB] reset mid-stream");
        @(negedge clk);
        pending = 2'b01;
        for (int c = 0; c < 10 && grant == 2'b00; c++) begin
            @(negedge clk);
            applyStimulus(0, randBeat(), 1'b1, 1'b0, '0, 1'b1);
            #1;
        end
        checkOutput("rst_pre_grant", DW'(grant), DW'(2'b01));
        @(negedge clk);
        applyStimulus(0, randBeat(), 1'b1, 1'b0, '0, 1'b1);
        #1;
        checkOutput("rst_pre_stream_val", DW'(insVal), DW'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_grant", DW'(grant), DW'(2'b00));
        checkOutput("rst_data_rdy", DW'(reqRdy), DW'(2'b00));
        checkOutput("rst_start", DW'(startPulse), DW'(1'b0));
        checkOutput("rst_ins_val", DW'(insVal), DW'(1'b0));
        checkOutput("rst_ins_data", insData, '0);
        checkOutput("rst_ins_last_pad", DW'({insLast, insPad}), DW'(0));
        checkOutput("rst_done_val", DW'(doneVal), DW'(2'b00));
        checkOutput("rst_done_data", DW'({doneFirst, doneCommit, doneHdr, doneData}), DW'(0));
        pending    = 2'b00;
        reqVal     = 2'b00;
        reqLast    = 2'b00;
        doneRdy    = 2'b00;
        logRdy     = 1'b0;
        lastServed = 1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pending = 2'b10;
        randomResults();
        serveOne(3, 2, 1'b0, 1);
        checkOutput("post_rst_idx", DW'(lastGrantIdx), DW'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
